// File: rtl/ix_unbundle_fifo_pkg.sv
// ---------------------------------------------------------------------------
// ix_unbundle_fifo_pkg
// Shared definitions for the decode-to-issue buffer. The layout of the
// 248-bit decoded-instruction bundle lives here as a packed struct, so the
// decode bundler and this queue share one description of the field order.
// Contents:
//   BUNDLE_W      bundle width in bits (248)
//   DEPTH_DEF     default queue depth
//   dec_bundle_t  packed bundle, first member is the MSB
// ---------------------------------------------------------------------------
package ix_unbundle_fifo_pkg;

   localparam int BUNDLE_W  = 248;
   localparam int DEPTH_DEF = 4;

   // Member order is the bit order: pc occupies [247:184], fencei is bit 0.
   typedef struct packed {
      logic [63:0] pc;          // [247:184]
      logic        bp;          // [183]
      logic [1:0]  bp_track;    // [182:181]
      logic [63:0] bt;          // [180:117]
      logic [3:0]  op;          // [116:113]
      logic        option;      // [112]
      logic        truncate;    // [111]
      logic [1:0]  br_type;     // [110:109]
      logic        br_neg;      // [108]
      logic        br_base_src; // [107]
      logic        br_inj_pc;   // [106]
      logic        br_is_call;  // [105]
      logic        br_is_ret;   // [104]
      logic        mem_sign;    // [103]
      logic [1:0]  mem_width;   // [102:101]
      logic [1:0]  csr_op;      // [100:99]
      logic        mret;        // [98]
      logic        intr;        // [97]
      logic [3:0]  cause;       // [96:93]
      logic [2:0]  md_op;       // [92:90]
      logic        muldiv;      // [89]
      logic [2:0]  op_type;     // [88:86]
      logic [1:0]  operand1;    // [85:84]
      logic [1:0]  operand2;    // [83:82]
      logic [63:0] imm;         // [81:18]
      logic        legal;       // [17]
      logic        wb_en;       // [16]
      logic [4:0]  rs1;         // [15:11]
      logic [4:0]  rs2;         // [10:6]
      logic [4:0]  rd;          // [5:1]
      logic        fencei;      // [0]
   } dec_bundle_t;

endpackage

// File: rtl/ix_unbundle_fifo_if.sv
// ---------------------------------------------------------------------------
// ix_unbundle_fifo_if
// Decode-side push handshake and issue-side head/pop handshake of the
// decode-to-issue buffer.
//   slave  : the buffer (takes dec_*, ix_ready, ix_flush; drives the rest)
//   master : the surrounding pipeline / environment
// Signals:
//   dec_bundle[247:0], dec_valid, dec_ready  decode push handshake
//   ix_valid, ix_ready, ix_flush, ix_count   issue handshake and occupancy
//   ix_<field>                               unpacked head-entry fields
// ---------------------------------------------------------------------------
interface ix_unbundle_fifo_if
   import ix_unbundle_fifo_pkg::*;
#(
   parameter int CNT_W = $clog2(DEPTH_DEF) + 1
);
   logic [BUNDLE_W-1:0] dec_bundle;
   logic                dec_valid;
   logic                dec_ready;
   logic                ix_valid;
   logic                ix_ready;
   logic                ix_flush;
   logic [CNT_W-1:0]    ix_count;
   logic [63:0]         ix_pc;
   logic                ix_bp;
   logic [1:0]          ix_bp_track;
   logic [63:0]         ix_bt;
   logic [3:0]          ix_op;
   logic                ix_option;
   logic                ix_truncate;
   logic [1:0]          ix_br_type;
   logic                ix_br_neg;
   logic                ix_br_base_src;
   logic                ix_br_inj_pc;
   logic                ix_br_is_call;
   logic                ix_br_is_ret;
   logic                ix_mem_sign;
   logic [1:0]          ix_mem_width;
   logic [1:0]          ix_csr_op;
   logic                ix_mret;
   logic                ix_intr;
   logic [3:0]          ix_cause;
   logic [2:0]          ix_md_op;
   logic                ix_muldiv;
   logic [2:0]          ix_op_type;
   logic [1:0]          ix_operand1;
   logic [1:0]          ix_operand2;
   logic [63:0]         ix_imm;
   logic                ix_legal;
   logic                ix_wb_en;
   logic [4:0]          ix_rs1;
   logic [4:0]          ix_rs2;
   logic [4:0]          ix_rd;
   logic                ix_fencei;

   modport slave (
      input  dec_bundle, dec_valid, ix_ready, ix_flush,
      output dec_ready, ix_valid, ix_count,
      output ix_pc, ix_bp, ix_bp_track, ix_bt, ix_op, ix_option, ix_truncate,
      output ix_br_type, ix_br_neg, ix_br_base_src, ix_br_inj_pc,
      output ix_br_is_call, ix_br_is_ret, ix_mem_sign, ix_mem_width,
      output ix_csr_op, ix_mret, ix_intr, ix_cause, ix_md_op, ix_muldiv,
      output ix_op_type, ix_operand1, ix_operand2, ix_imm, ix_legal,
      output ix_wb_en, ix_rs1, ix_rs2, ix_rd, ix_fencei
   );

   modport master (
      output dec_bundle, dec_valid, ix_ready, ix_flush,
      input  dec_ready, ix_valid, ix_count,
      input  ix_pc, ix_bp, ix_bp_track, ix_bt, ix_op, ix_option, ix_truncate,
      input  ix_br_type, ix_br_neg, ix_br_base_src, ix_br_inj_pc,
      input  ix_br_is_call, ix_br_is_ret, ix_mem_sign, ix_mem_width,
      input  ix_csr_op, ix_mret, ix_intr, ix_cause, ix_md_op, ix_muldiv,
      input  ix_op_type, ix_operand1, ix_operand2, ix_imm, ix_legal,
      input  ix_wb_en, ix_rs1, ix_rs2, ix_rd, ix_fencei
   );
endinterface

// File: rtl/ix_unbundle_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// ix_unbundle_fifo_ctrl
// Generic pointer/occupancy control for a power-of-two circular queue.
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_push_req           producer offers an entry
//   i_pop_req            consumer takes the head entry
//   i_flush              drop all entries on the next edge
//   o_push               write strobe for the storage array (accepted push)
//   o_full, o_empty      occupancy flags, derived from the count register
//   o_wp, o_rp           write / read pointers
//   o_count              occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module ix_unbundle_fifo_ctrl #(
   parameter  int DEPTH = 4,
   parameter  int CNT_W = $clog2(DEPTH) + 1,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push_req,
   input  logic             i_pop_req,
   input  logic             i_flush,
   output logic             o_push,
   output logic             o_full,
   output logic             o_empty,
   output logic [PTR_W-1:0] o_wp,
   output logic [PTR_W-1:0] o_rp,
   output logic [CNT_W-1:0] o_count
);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0] r_wp;
   logic [PTR_W-1:0] r_rp;
   logic [CNT_W-1:0] r_count;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;

   // Full/empty come from the count, so equal pointers are never ambiguous.
   assign w_full  = (r_count == FULL_CNT);
   assign w_empty = (r_count == '0);

   // Full blocks a push even when a pop happens in the same cycle: this keeps
   // the consumer's ready off the producer's ready path. Flush and reset
   // also cancel the push so the array is never written for a dropped bundle.
   assign w_push = i_push_req && !w_full  && !i_flush && !i_rst;
   assign w_pop  = i_pop_req  && !w_empty && !i_flush && !i_rst;

   // Pointer and occupancy state; reset wins over flush, flush over traffic.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wp <= r_wp + PTR_W'(1);
         end
         if (w_pop) begin
            r_rp <= r_rp + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_push  = w_push;
   assign o_full  = w_full;
   assign o_empty = w_empty;
   assign o_wp    = r_wp;
   assign o_rp    = r_rp;
   assign o_count = r_count;

endmodule

// File: rtl/ix_unbundle_fifo.sv
// ---------------------------------------------------------------------------
// ix_unbundle_fifo
// Decode-to-issue buffer: stores decoded-instruction bundles in a small
// circular queue and presents the head entry to issue as unpacked fields.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   bus (slave)    dec_bundle/dec_valid/dec_ready push side,
//                  ix_valid/ix_ready/ix_flush/ix_count and ix_<field> head
// All outputs are functions of registers only (count, rp, storage array).
// ---------------------------------------------------------------------------
module ix_unbundle_fifo
   import ix_unbundle_fifo_pkg::*;
#(
   parameter  int DEPTH = DEPTH_DEF,
   parameter  int CNT_W = $clog2(DEPTH) + 1,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic                i_clk,
   input  logic                i_rst,
   ix_unbundle_fifo_if.slave   bus
);
   dec_bundle_t      r_mem [DEPTH];
   logic             w_push;
   logic             w_full;
   logic             w_empty;
   logic [PTR_W-1:0] w_wp;
   logic [PTR_W-1:0] w_rp;
   logic [CNT_W-1:0] w_count;
   dec_bundle_t      w_head;

   ix_unbundle_fifo_ctrl #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_ctrl (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_push_req (bus.dec_valid),
      .i_pop_req  (bus.ix_ready),
      .i_flush    (bus.ix_flush),
      .o_push     (w_push),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_wp       (w_wp),
      .o_rp       (w_rp),
      .o_count    (w_count)
   );

   // Bundle storage; contents are kept across flush and reset, only the
   // pointers move, so the head fields stay stable while empty.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[w_wp] <= bus.dec_bundle;
      end
   end

   assign bus.dec_ready = !w_full;
   assign bus.ix_valid  = !w_empty;
   assign bus.ix_count  = w_count;

   // Head entry is read straight from the array: no bypass when empty.
   assign w_head = r_mem[w_rp];

   assign bus.ix_pc          = w_head.pc;
   assign bus.ix_bp          = w_head.bp;
   assign bus.ix_bp_track    = w_head.bp_track;
   assign bus.ix_bt          = w_head.bt;
   assign bus.ix_op          = w_head.op;
   assign bus.ix_option      = w_head.option;
   assign bus.ix_truncate    = w_head.truncate;
   assign bus.ix_br_type     = w_head.br_type;
   assign bus.ix_br_neg      = w_head.br_neg;
   assign bus.ix_br_base_src = w_head.br_base_src;
   assign bus.ix_br_inj_pc   = w_head.br_inj_pc;
   assign bus.ix_br_is_call  = w_head.br_is_call;
   assign bus.ix_br_is_ret   = w_head.br_is_ret;
   assign bus.ix_mem_sign    = w_head.mem_sign;
   assign bus.ix_mem_width   = w_head.mem_width;
   assign bus.ix_csr_op      = w_head.csr_op;
   assign bus.ix_mret        = w_head.mret;
   assign bus.ix_intr        = w_head.intr;
   assign bus.ix_cause       = w_head.cause;
   assign bus.ix_md_op       = w_head.md_op;
   assign bus.ix_muldiv      = w_head.muldiv;
   assign bus.ix_op_type     = w_head.op_type;
   assign bus.ix_operand1    = w_head.operand1;
   assign bus.ix_operand2    = w_head.operand2;
   assign bus.ix_imm         = w_head.imm;
   assign bus.ix_legal       = w_head.legal;
   assign bus.ix_wb_en       = w_head.wb_en;
   assign bus.ix_rs1         = w_head.rs1;
   assign bus.ix_rs2         = w_head.rs2;
   assign bus.ix_rd          = w_head.rd;
   assign bus.ix_fencei      = w_head.fencei;

endmodule

// File: tb/tb_ix_unbundle_fifo.sv
// ---------------------------------------------------------------------------
// tb_ix_unbundle_fifo
// Directed table-driven bench for the decode-to-issue buffer (DEPTH=4).
// ---------------------------------------------------------------------------
module tb_ix_unbundle_fifo;

   logic clk;
   logic rst;
   int   n_total;
   int   n_pass;

   ix_unbundle_fifo_if #(.CNT_W(3)) bus ();

   ix_unbundle_fifo #(.DEPTH(4), .CNT_W(3)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        push;
      logic [63:0] pc;
      logic        pop;
      logic        flush;
      logic        er;   // expected dec_ready after the edge
      logic        ev;   // expected ix_valid after the edge
      logic [2:0]  ec;   // expected ix_count after the edge
      logic [63:0] epc;  // expected head pc when ev=1
   } vec_t;

   vec_t vec[$];

   localparam logic [63:0] IMM_MASK = 64'h0F0F_F0F0_3C3C_A5A5;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Traffic bundle: pc, bt=~pc, imm=pc^mask, everything else zero.
   function automatic logic [247:0] mk(input logic [63:0] pc);
      logic [247:0] b;
      b = 248'd0;
      b[247:184] = pc;
      b[180:117] = ~pc;
      b[81:18]   = pc ^ IMM_MASK;
      return b;
   endfunction

   task automatic add(input logic push, input logic [63:0] pc, input logic pop,
                      input logic flush, input logic er, input logic ev,
                      input logic [2:0] ec, input logic [63:0] epc);
      vec_t v;
      v.push = push; v.pc = pc; v.pop = pop; v.flush = flush;
      v.er = er; v.ev = ev; v.ec = ec; v.epc = epc;
      vec.push_back(v);
   endtask

   task automatic step(input logic push, input logic [63:0] pc, input logic pop, input logic flush);
      bus.dec_valid  = push;
      bus.dec_bundle = mk(pc);
      bus.ix_ready   = pop;
      bus.ix_flush   = flush;
      @(posedge clk);
      #1;
      bus.dec_valid = 1'b0;
      bus.ix_ready  = 1'b0;
      bus.ix_flush  = 1'b0;
   endtask

   // Hand-chosen field values for the full-layout check.
   logic [63:0] f_pc, f_bt, f_imm;
   logic        f_bp, f_option, f_truncate, f_br_neg, f_br_base_src, f_br_inj_pc;
   logic        f_br_is_call, f_br_is_ret, f_mem_sign, f_mret, f_intr, f_muldiv;
   logic        f_legal, f_wb_en, f_fencei;
   logic [1:0]  f_bp_track, f_br_type, f_mem_width, f_csr_op, f_operand1, f_operand2;
   logic [3:0]  f_op, f_cause;
   logic [2:0]  f_md_op, f_op_type;
   logic [4:0]  f_rs1, f_rs2, f_rd;

   initial begin
      n_total = 0;
      n_pass  = 0;
      rst = 1'b1;
      bus.dec_valid  = 1'b0;
      bus.dec_bundle = 248'd0;
      bus.ix_ready   = 1'b0;
      bus.ix_flush   = 1'b0;

      // Reset then idle
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_dec_ready", 64'(bus.dec_ready), 64'd1);
      chk("rst_ix_valid",  64'(bus.ix_valid),  64'd0);
      chk("rst_ix_count",  64'(bus.ix_count),  64'd0);

      // Single push with every field distinct, checked against its own constant
      f_pc = 64'h0000_0000_8000_0000; f_bp = 1'b1; f_bp_track = 2'b10;
      f_bt = 64'h0000_0000_8000_0100; f_op = 4'hB; f_option = 1'b1; f_truncate = 1'b0;
      f_br_type = 2'b01; f_br_neg = 1'b1; f_br_base_src = 1'b0; f_br_inj_pc = 1'b1;
      f_br_is_call = 1'b0; f_br_is_ret = 1'b1; f_mem_sign = 1'b0; f_mem_width = 2'b11;
      f_csr_op = 2'b10; f_mret = 1'b1; f_intr = 1'b0; f_cause = 4'h9; f_md_op = 3'b101;
      f_muldiv = 1'b1; f_op_type = 3'b110; f_operand1 = 2'b01; f_operand2 = 2'b10;
      f_imm = 64'hFFFF_FFFF_FFFF_F800; f_legal = 1'b1; f_wb_en = 1'b0;
      f_rs1 = 5'd17; f_rs2 = 5'd9; f_rd = 5'd30; f_fencei = 1'b1;
      bus.dec_bundle = {f_pc, f_bp, f_bp_track, f_bt, f_op, f_option, f_truncate,
                        f_br_type, f_br_neg, f_br_base_src, f_br_inj_pc, f_br_is_call,
                        f_br_is_ret, f_mem_sign, f_mem_width, f_csr_op, f_mret, f_intr,
                        f_cause, f_md_op, f_muldiv, f_op_type, f_operand1, f_operand2,
                        f_imm, f_legal, f_wb_en, f_rs1, f_rs2, f_rd, f_fencei};
      bus.dec_valid = 1'b1;
      #1;
      chk("no_bypass_valid", 64'(bus.ix_valid), 64'd0);
      @(posedge clk);
      #1;
      bus.dec_valid = 1'b0;
      chk("f_valid",       64'(bus.ix_valid),       64'd1);
      chk("f_count",       64'(bus.ix_count),       64'd1);
      chk("f_pc",          bus.ix_pc,               f_pc);
      chk("f_bp",          64'(bus.ix_bp),          64'(f_bp));
      chk("f_bp_track",    64'(bus.ix_bp_track),    64'(f_bp_track));
      chk("f_bt",          bus.ix_bt,               f_bt);
      chk("f_op",          64'(bus.ix_op),          64'(f_op));
      chk("f_option",      64'(bus.ix_option),      64'(f_option));
      chk("f_truncate",    64'(bus.ix_truncate),    64'(f_truncate));
      chk("f_br_type",     64'(bus.ix_br_type),     64'(f_br_type));
      chk("f_br_neg",      64'(bus.ix_br_neg),      64'(f_br_neg));
      chk("f_br_base_src", 64'(bus.ix_br_base_src), 64'(f_br_base_src));
      chk("f_br_inj_pc",   64'(bus.ix_br_inj_pc),   64'(f_br_inj_pc));
      chk("f_br_is_call",  64'(bus.ix_br_is_call),  64'(f_br_is_call));
      chk("f_br_is_ret",   64'(bus.ix_br_is_ret),   64'(f_br_is_ret));
      chk("f_mem_sign",    64'(bus.ix_mem_sign),    64'(f_mem_sign));
      chk("f_mem_width",   64'(bus.ix_mem_width),   64'(f_mem_width));
      chk("f_csr_op",      64'(bus.ix_csr_op),      64'(f_csr_op));
      chk("f_mret",        64'(bus.ix_mret),        64'(f_mret));
      chk("f_intr",        64'(bus.ix_intr),        64'(f_intr));
      chk("f_cause",       64'(bus.ix_cause),       64'(f_cause));
      chk("f_md_op",       64'(bus.ix_md_op),       64'(f_md_op));
      chk("f_muldiv",      64'(bus.ix_muldiv),      64'(f_muldiv));
      chk("f_op_type",     64'(bus.ix_op_type),     64'(f_op_type));
      chk("f_operand1",    64'(bus.ix_operand1),    64'(f_operand1));
      chk("f_operand2",    64'(bus.ix_operand2),    64'(f_operand2));
      chk("f_imm",         bus.ix_imm,              f_imm);
      chk("f_legal",       64'(bus.ix_legal),       64'(f_legal));
      chk("f_wb_en",       64'(bus.ix_wb_en),       64'(f_wb_en));
      chk("f_rs1",         64'(bus.ix_rs1),         64'(f_rs1));
      chk("f_rs2",         64'(bus.ix_rs2),         64'(f_rs2));
      chk("f_rd",          64'(bus.ix_rd),          64'(f_rd));
      chk("f_fencei",      64'(bus.ix_fencei),      64'(f_fencei));
      bus.ix_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.ix_ready = 1'b0;
      chk("f_pop_valid", 64'(bus.ix_valid), 64'd0);
      chk("f_pop_count", 64'(bus.ix_count), 64'd0);

      // Fill to full, 5th push dropped, full push+pop rejects push, drain in order
      add(1'b1, 64'h1000, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 64'h1000);
      add(1'b1, 64'h1001, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 64'h1000);
      add(1'b1, 64'h1002, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 64'h1000);
      add(1'b1, 64'h1003, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 64'h1000);
      add(1'b1, 64'h1004, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 64'h1000);
      add(1'b1, 64'h1004, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 64'h1001);
      add(1'b0, 64'h0,    1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 64'h1002);
      add(1'b0, 64'h0,    1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 64'h1003);
      add(1'b0, 64'h0,    1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 64'h0);
      add(1'b0, 64'h0,    1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 64'h0);
      // Streaming from empty: pop on empty ignored, then count steady at 1
      for (int k = 0; k < 10; k++) begin
         add(1'b1, 64'h2000 + 64'(k), 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 64'h2000 + 64'(k));
      end
      add(1'b0, 64'h0,    1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 64'h0);
      // Flush at count 3 with push and pop in the same cycle
      add(1'b1, 64'h3000, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 64'h3000);
      add(1'b1, 64'h3001, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 64'h3000);
      add(1'b1, 64'h3002, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 64'h3000);
      add(1'b1, 64'h3003, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 64'h0);
      add(1'b1, 64'h3100, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 64'h3100);
      add(1'b0, 64'h0,    1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 64'h0);

      for (int i = 0; i < vec.size(); i++) begin
         step(vec[i].push, vec[i].pc, vec[i].pop, vec[i].flush);
         chk($sformatf("v%0d_dec_ready", i), 64'(bus.dec_ready), 64'(vec[i].er));
         chk($sformatf("v%0d_ix_valid", i),  64'(bus.ix_valid),  64'(vec[i].ev));
         chk($sformatf("v%0d_ix_count", i),  64'(bus.ix_count),  64'(vec[i].ec));
         if (vec[i].ev) begin
            chk($sformatf("v%0d_ix_pc", i),  bus.ix_pc,  vec[i].epc);
            chk($sformatf("v%0d_ix_bt", i),  bus.ix_bt,  ~vec[i].epc);
            chk($sformatf("v%0d_ix_imm", i), bus.ix_imm, vec[i].epc ^ IMM_MASK);
         end
      end

      // Reset mid-stream overrides a simultaneous push and pop
      step(1'b1, 64'h4000, 1'b0, 1'b0);
      step(1'b1, 64'h4001, 1'b0, 1'b0);
      chk("mid_pre_count", 64'(bus.ix_count), 64'd2);
      rst = 1'b1;
      step(1'b1, 64'h4002, 1'b1, 1'b0);
      rst = 1'b0;
      chk("mid_rst_count", 64'(bus.ix_count),  64'd0);
      chk("mid_rst_valid", 64'(bus.ix_valid),  64'd0);
      chk("mid_rst_ready", 64'(bus.dec_ready), 64'd1);
      step(1'b1, 64'h4100, 1'b0, 1'b0);
      chk("mid_after_count", 64'(bus.ix_count), 64'd1);
      chk("mid_after_pc",    bus.ix_pc,         64'h4100);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
